// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction SRAM and
// presents {valid, pc, inst} to ID, honouring stall holds and EX branch redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          STALL_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STALL_W-1:0] stall,
  input  logic               br_e,
  input  logic [31:0]        br_addr,
  output logic               inst_sram_en,
  output logic [31:0]        inst_sram_addr,
  input  logic [31:0]        inst_sram_rdata,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_inst,
  output logic               if_misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc_q,  pc_d;
  logic        fv_q,  fv_d;
  logic        bv_q,  bv_d;
  logic [31:0] buf_q, buf_d;

  logic        hold;
  logic [31:0] pc_nxt;
  logic        unused_stall_hi;

  assign hold            = stall[0] | stall[1];
  assign unused_stall_hi = ^stall[STALL_W-1:2];

  // Redirect beats hold; a hold or an empty pipe re-issues the current PC.
  always_comb begin
    if (br_e)       pc_nxt = br_addr;
    else if (hold)  pc_nxt = pc_q;
    else if (!fv_q) pc_nxt = pc_q;
    else            pc_nxt = pc_q + 32'd4;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pc_d  = pc_q;
    fv_d  = fv_q;
    bv_d  = bv_q;
    buf_d = buf_q;
    if (br_e) begin
      pc_d = br_addr;
      fv_d = 1'b1;
      bv_d = 1'b0;
    end else if (hold) begin
      // The SRAM is idle while held, so capture its word once, on the first hold cycle.
      if (fv_q && !bv_q) begin
        buf_d = inst_sram_rdata;
        bv_d  = 1'b1;
      end
    end else begin
      pc_d = pc_nxt;
      fv_d = 1'b1;
      bv_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the buffer word is reset
  // too, since it is a single register rather than a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      fv_q  <= 1'b0;
      bv_q  <= 1'b0;
      buf_q <= '0;
    end else begin
      pc_q  <= pc_d;
      fv_q  <= fv_d;
      bv_q  <= bv_d;
      buf_q <= buf_d;
    end
  end

  assign inst_sram_en   = rst_n & (br_e | ~hold);
  assign inst_sram_addr = rst_n ? {pc_nxt[31:2], 2'b00} : RESET_PC;

  assign if_valid    = fv_q & ~br_e;
  assign if_pc       = pc_q;
  assign if_inst     = !if_valid ? NOP : (bv_q ? buf_q : inst_sram_rdata);
  assign if_misalign = if_valid & (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_if_stage.sv
// Scoreboarded bench for if_stage: a transaction-level fetch model predicts each cycle's
// outputs into a queue, and a negedge monitor pops and compares them.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  stall = '0;
  logic        br_e = 1'b0;
  logic [31:0] br_addr = '0;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_misalign;

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: PC of the instruction owned by IF and whether one is live.
  logic [31:0] m_pc   = RESET_PC;
  logic        m_live = 1'b0;

  if_stage #(.RESET_PC(RESET_PC), .STALL_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .br_e            (br_e),
    .br_addr         (br_addr),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .if_misalign     (if_misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A5_0000;
  endfunction

  // Synchronous SRAM: garbage when not enabled, so a missing buffer shows up.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
    else              inst_sram_rdata <= $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus: drive inputs, predict outputs, advance the model.
  task automatic cycle(input logic r, input logic [7:0] st, input logic b,
                       input logic [31:0] ba);
    exp_t        e;
    logic        hold;
    logic [31:0] nxt;
    @(posedge clk);
    #1;
    rst_n   = r;
    stall   = st;
    br_e    = b;
    br_addr = ba;
    if (!r) begin
      m_live = 1'b0;
      m_pc   = RESET_PC;
      e = '{en: 1'b0, addr: RESET_PC, valid: 1'b0, pc: RESET_PC, inst: NOP, mis: 1'b0};
    end else begin
      hold    = st[0] | st[1];
      e.valid = m_live && !b;
      e.pc    = m_pc;
      e.inst  = e.valid ? mem_word(m_pc) : NOP;
      e.mis   = e.valid && (m_pc[1:0] != 2'b00);
      e.en    = b || !hold;
      if (b)            nxt = ba;
      else if (hold)    nxt = m_pc;
      else if (!m_live) nxt = m_pc;
      else              nxt = m_pc + 32'd4;
      e.addr = {nxt[31:2], 2'b00};
      if (e.en) begin
        m_pc   = nxt;
        m_live = 1'b1;
      end
    end
    expq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("sram_en",   {31'd0, inst_sram_en}, {31'd0, e.en});
        check("sram_addr", inst_sram_addr, e.addr);
        check("if_valid",  {31'd0, if_valid}, {31'd0, e.valid});
        check("if_pc",     if_pc, e.pc);
        check("if_inst",   if_inst, e.inst);
        check("misalign",  {31'd0, if_misalign}, {31'd0, e.mis});
      end
    end
  end

  initial begin : stimulus
    int          wait_cycles;
    logic        r;
    logic [7:0]  st;
    logic        b;
    logic [31:0] ba;

    repeat (3) cycle(1'b0, 8'h00, 1'b0, '0);

    // Straight-line fetch, then a 3-cycle stall while 8000_0008 is presented.
    repeat (3) cycle(1'b1, 8'h00, 1'b0, '0);
    cycle(1'b1, 8'h01, 1'b0, '0);
    cycle(1'b1, 8'h02, 1'b0, '0);
    cycle(1'b1, 8'h03, 1'b0, '0);
    cycle(1'b1, 8'h00, 1'b0, '0);
    cycle(1'b1, 8'hFC, 1'b0, '0);
    cycle(1'b1, 8'h00, 1'b0, '0);

    // Redirect in a normal cycle, then back-to-back redirects.
    cycle(1'b1, 8'h00, 1'b1, 32'h8000_0100);
    repeat (2) cycle(1'b1, 8'h00, 1'b0, '0);
    cycle(1'b1, 8'h00, 1'b1, 32'h8000_0040);
    cycle(1'b1, 8'h00, 1'b1, 32'h8000_0080);
    cycle(1'b1, 8'h00, 1'b0, '0);

    // Redirect during a stall with a filled buffer: stale word must not reappear.
    repeat (2) cycle(1'b1, 8'h01, 1'b0, '0);
    cycle(1'b1, 8'h0F, 1'b1, 32'h8000_0200);
    repeat (2) cycle(1'b1, 8'h02, 1'b0, '0);
    repeat (2) cycle(1'b1, 8'h00, 1'b0, '0);

    // Misaligned target.
    cycle(1'b1, 8'h00, 1'b1, 32'h8000_0102);
    repeat (2) cycle(1'b1, 8'h00, 1'b0, '0);

    // PC wrap past the top of the address space.
    cycle(1'b1, 8'h00, 1'b1, 32'hFFFF_FFFC);
    repeat (3) cycle(1'b1, 8'h00, 1'b0, '0);

    // Reset pulse mid-stall with a filled buffer.
    repeat (3) cycle(1'b1, 8'h01, 1'b0, '0);
    repeat (2) cycle(1'b0, 8'h01, 1'b0, '0);
    cycle(1'b1, 8'h01, 1'b0, '0);
    repeat (3) cycle(1'b1, 8'h00, 1'b0, '0);

    for (int i = 0; i < 500; i++) begin
      r  = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 9) < 3) ? 8'($urandom_range(1, 255) | 1) : 8'($urandom & 8'hFC);
      b  = ($urandom_range(0, 6) == 0);
      ba = 32'h8000_0000 + 32'($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 7) == 0) ba[1:0] = 2'($urandom_range(1, 3));
      cycle(r, st, b, ba);
    end
    cycle(1'b1, 8'h00, 1'b0, '0);

    wait_cycles = 0;
    while (expq.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    check("drain", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
